bypass_control: RTL and testbench
=================================

BYPASS_CONTROL -- requirements
Module: bypass_control

Interface
REQ-001 SHALL declare ports in this order: clock input 1, pipeline clock, rising edge.
REQ-002 SHALL declare reset input 1, asynchronous, active-high.
REQ-003 SHALL declare pipe_en input 1, global pipeline advance; when 0 all stages hold.
REQ-004 SHALL declare flush input 1, kills the decode-stage instruction when it would enter EX.
REQ-005 SHALL declare id_valid input 1, the decode stage holds a real instruction.
REQ-006 SHALL declare IFIDIR input 32, the instruction in decode.
REQ-007 SHALL declare outputs bypassAfromMEM, bypassAfromALUinWB and bypassAfromLDinWB, each 1, rs1 forwarding selects for the EX-stage instruction.
REQ-008 SHALL declare outputs bypassBfromMEM, bypassBfromALUinWB and bypassBfromLDinWB, each 1, rs2 forwarding selects for the EX-stage instruction.
REQ-009 SHALL declare stallID output 1, load-use hazard; freezes PC and IF/ID.
REQ-010 SHALL declare stall_count output 16, number of load-use bubbles inserted.

Function
REQ-011 SHALL keep three shadow entries IDEX, EXMEM and MEMWB, each {valid, op[6:0], rd[4:0], rs1[4:0], rs2[4:0]}, decoded from IR bits [6:0], [11:7], [19:15] and [24:20].
REQ-012 SHALL treat ALUopR, ALUopI and LW as writing rd; an entry with rd==0 SHALL never cause forwarding or a stall.
REQ-013 SHALL treat ALUopR, ALUopI, LW, SW and BEQ as reading rs1, and ALUopR, SW and BEQ as reading rs2.
REQ-014 SHALL, on a clock edge with pipe_en=1, shift MEMWB<=EXMEM and EXMEM<=IDEX in the same edge.
REQ-015 SHALL, on that same edge, load IDEX with a bubble (valid=0) if stallID or flush or !id_valid, otherwise with the decode of IFIDIR.
REQ-016 SHALL, on a clock edge with pipe_en=0, hold all three entries and stall_count.
REQ-017 SHALL drive stallID=1 combinationally iff IDEX is a valid LW with rd!=0, id_valid=1, flush=0, and rd equals an rs1 or rs2 that IFIDIR actually reads.
REQ-018 SHALL drive bypassXfromMEM=1 iff EXMEM is a valid ALUopR or ALUopI, rd!=0, and rd equals the IDEX source X (X=A for rs1, X=B for rs2), with IDEX valid and reading X.
REQ-019 SHALL drive bypassXfromALUinWB=1 iff MEMWB is a valid ALUopR or ALUopI matching source X and bypassXfromMEM=0; the youngest producer wins.
REQ-020 SHALL drive bypassXfromLDinWB=1 iff MEMWB is a valid LW matching source X and bypassXfromMEM=0.
REQ-021 SHALL ensure at most one of the three selects per operand is 1 at any time.
REQ-022 SHALL never assert any select due to a LW in EXMEM; that hazard is covered by stallID.
REQ-023 SHALL increment stall_count on every edge with pipe_en=1 and stallID=1, saturating at 0xFFFF.
REQ-024 SHALL compute all bypass outputs from registered state only (no IFIDIR path); stallID SHALL depend on IDEX and IFIDIR.
REQ-025 SHALL let flush take precedence over stallID when both are active; the flushed instruction SHALL cause no stall.

Reset
REQ-026 SHALL, on reset, clear all shadow entries to valid=0 with zero fields and set stall_count=0, immediately and without waiting for a clock edge.
REQ-027 SHALL hold all bypass outputs and stallID at 0 during reset and on the first cycle after it.

Structure
REQ-028 SHALL take opcode constants ALUopR, ALUopI, LW, SW and BEQ from the shared Opcodes package.
REQ-029 SHALL place the stage-entry struct type in that package.
REQ-030 SHALL implement the IR-to-entry decode as one sub-module, stage_decode, instantiated for IFIDIR.
REQ-031 SHALL connect its select outputs one-to-one to ALUInputSelect inputs of the same name.

Verification
REQ-032 SHALL cover: addi x5,x0,1 then add x6,x5,x5 back-to-back -> when the add is in EX, bypassAfromMEM=1 and bypassBfromMEM=1; all others 0.
REQ-033 SHALL cover: addi x5 then nop then sub x7,x5,x1 -> bypassAfromALUinWB=1, bypassBfromALUinWB=0.
REQ-034 SHALL cover: lw x8,0(x1) then add x9,x8,x2 -> stallID=1 for exactly one cycle and stall_count 0->1; next cycle bypassAfromLDinWB=1.
REQ-035 SHALL cover: addi x5,x0,1; addi x5,x0,2; add x6,x5,x0 -> bypassAfromMEM=1 and bypassAfromALUinWB=0, so the younger value is chosen.
REQ-036 SHALL cover: lw x0,0(x1) then add x3,x0,x0 -> stallID=0 and no select asserted.
REQ-037 SHALL cover: pipe_en=0 for 3 cycles mid-hazard -> outputs and stall_count frozen; reset asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/Opcodes.sv
// Shared opcode constants, the pipeline shadow-entry type and small decode
// predicates used by the bypass/stall logic.
package Opcodes;

    localparam logic [6:0] ALUopR = 7'b0110011;
    localparam logic [6:0] ALUopI = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BEQ    = 7'b1100011;

    typedef struct packed {
        logic       valid;
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } stage_entry_t;

    function automatic logic is_alu(input logic [6:0] op);
        return (op == ALUopR) || (op == ALUopI);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == ALUopR) || (op == ALUopI) || (op == LW) || (op == SW) || (op == BEQ);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == ALUopR) || (op == SW) || (op == BEQ);
    endfunction

    // A live entry targeting src; x0 is hardwired and never a real producer.
    function automatic logic produces(input stage_entry_t e, input logic [4:0] src);
        return e.valid && (e.rd != 5'd0) && (e.rd == src);
    endfunction

endpackage

// File: rtl/stage_decode.sv
// Splits a raw instruction word into a pipeline shadow entry.
module stage_decode
    import Opcodes::*;
(
    input  logic [31:0]  ir_i,
    input  logic         valid_i,
    output stage_entry_t entry_o
);

    // funct3/funct7 play no part in hazard detection.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_i[31:25], ir_i[14:12]};

    assign entry_o.valid = valid_i;
    assign entry_o.op    = ir_i[6:0];
    assign entry_o.rd    = ir_i[11:7];
    assign entry_o.rs1   = ir_i[19:15];
    assign entry_o.rs2   = ir_i[24:20];

endmodule

// File: rtl/bypass_control.sv
// Forwarding-select and load-use stall control for a 5-stage pipeline, driven
// by shadow copies of the ID/EX, EX/MEM and MEM/WB instruction fields.
module bypass_control
    import Opcodes::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_en,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] IFIDIR,
    output logic        bypassAfromMEM,
    output logic        bypassAfromALUinWB,
    output logic        bypassAfromLDinWB,
    output logic        bypassBfromMEM,
    output logic        bypassBfromALUinWB,
    output logic        bypassBfromLDinWB,
    output logic        stallID,
    output logic [15:0] stall_count
);

    stage_entry_t id_dec;
    stage_entry_t idex_q, idex_d;
    stage_entry_t exmem_q;
    stage_entry_t memwb_q;
    logic [15:0]  stall_count_q, stall_count_d;

    stage_decode u_decode (
        .ir_i    (IFIDIR),
        .valid_i (id_valid),
        .entry_o (id_dec)
    );

    // Once in WB an entry only feeds forwarding by its destination.
    logic unused_wb_sources;
    assign unused_wb_sources = ^{memwb_q.rs1, memwb_q.rs2};

    // Load-use: the decode instruction needs a value the EX-stage load has not fetched yet.
    logic load_use_rs1, load_use_rs2;
    assign load_use_rs1 = reads_rs1(id_dec.op) && (id_dec.rs1 == idex_q.rd);
    assign load_use_rs2 = reads_rs2(id_dec.op) && (id_dec.rs2 == idex_q.rd);
    assign stallID = idex_q.valid && (idex_q.op == LW) && (idex_q.rd != 5'd0)
                   && id_valid && !flush && (load_use_rs1 || load_use_rs2);

    logic a_live, b_live;
    assign a_live = idex_q.valid && reads_rs1(idex_q.op);
    assign b_live = idex_q.valid && reads_rs2(idex_q.op);

    // MEM is the youngest producer and masks anything older in WB.
    assign bypassAfromMEM     = a_live && is_alu(exmem_q.op) && produces(exmem_q, idex_q.rs1);
    assign bypassAfromALUinWB = a_live && is_alu(memwb_q.op) && produces(memwb_q, idex_q.rs1)
                              && !bypassAfromMEM;
    assign bypassAfromLDinWB  = a_live && (memwb_q.op == LW) && produces(memwb_q, idex_q.rs1)
                              && !bypassAfromMEM;

    assign bypassBfromMEM     = b_live && is_alu(exmem_q.op) && produces(exmem_q, idex_q.rs2);
    assign bypassBfromALUinWB = b_live && is_alu(memwb_q.op) && produces(memwb_q, idex_q.rs2)
                              && !bypassBfromMEM;
    assign bypassBfromLDinWB  = b_live && (memwb_q.op == LW) && produces(memwb_q, idex_q.rs2)
                              && !bypassBfromMEM;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idex_d        = id_dec;
        stall_count_d = stall_count_q;
        if (stallID || flush || !id_valid) begin
            idex_d = '0;
        end
        if (stallID && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // NOTE: state uses non-blocking assignments so all three stages shift on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex_q        <= '0;
            exmem_q       <= '0;
            memwb_q       <= '0;
            stall_count_q <= '0;
        end else if (pipe_en) begin
            idex_q        <= idex_d;
            exmem_q       <= idex_q;
            memwb_q       <= exmem_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_bypass_control.sv
// Scenario bench for bypass_control: each decode-stage instruction queues the
// forwarding selects expected once it sits in EX; they are checked after the edge.
module tb_bypass_control;

    logic        clock;
    logic        reset;
    logic        pipe_en;
    logic        flush;
    logic        id_valid;
    logic [31:0] IFIDIR;
    logic        bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB;
    logic        bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB;
    logic        stallID;
    logic [15:0] stall_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      name;
        logic [5:0] sel;
    } exp_t;

    exp_t sb[$];

    logic [5:0] sel_now;
    assign sel_now = {bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB,
                      bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB};

    bypass_control dut (
        .clock              (clock),
        .reset              (reset),
        .pipe_en            (pipe_en),
        .flush              (flush),
        .id_valid           (id_valid),
        .IFIDIR             (IFIDIR),
        .bypassAfromMEM     (bypassAfromMEM),
        .bypassAfromALUinWB (bypassAfromALUinWB),
        .bypassAfromLDinWB  (bypassAfromLDinWB),
        .bypassBfromMEM     (bypassBfromMEM),
        .bypassBfromALUinWB (bypassBfromALUinWB),
        .bypassBfromLDinWB  (bypassBfromLDinWB),
        .stallID            (stallID),
        .stall_count        (stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // RISC-V encoders
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_sub(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Clock edge, then pop the oldest queued expectation and compare the selects.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: selects=%b with nothing expected", sel_now);
        end else begin
            e = sb.pop_front();
            if (sel_now !== e.sel)
                $display("FAIL %s: selects=%b expected %b", e.name, sel_now, e.sel);
            else
                passed++;
        end
    endtask

    task automatic issue(input string name, input logic [31:0] ir, input logic exp_stall,
                         input logic [5:0] exp_sel);
        @(negedge clock);
        IFIDIR   = ir;
        id_valid = 1'b1;
        flush    = 1'b0;
        pipe_en  = 1'b1;
        #1;
        total++;
        if (stallID !== exp_stall)
            $display("FAIL %s_stall: stallID=%b expected %b", name, stallID, exp_stall);
        else
            passed++;
        sb.push_back('{name, exp_sel});
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) issue("drain", NOP, 1'b0, 6'b000000);
    endtask

    task automatic check_count(input string name, input logic [15:0] exp);
        total++;
        if (stall_count !== exp)
            $display("FAIL %s: stall_count=%0d expected %0d", name, stall_count, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (sel_now !== 6'b0 || stallID !== 1'b0)
            $display("FAIL reset_outputs: selects=%b stallID=%b expected 0", sel_now, stallID);
        else
            passed++;
        check_count("reset_count", 16'd0);
        @(negedge clock);
        reset = 1'b0;
        issue("first_after_reset", enc_add(5'd6, 5'd5, 5'd5), 1'b0, 6'b000000);
        drain();
    endtask

    task automatic test_alu_mem_forward();
        issue("addi_x5", enc_addi(5'd5, 5'd0, 12'd1), 1'b0, 6'b000000);
        issue("add_mem_fwd", enc_add(5'd6, 5'd5, 5'd5), 1'b0, 6'b100100);
        drain();
    endtask

    task automatic test_alu_wb_forward();
        issue("addi_x5_wb", enc_addi(5'd5, 5'd0, 12'd1), 1'b0, 6'b000000);
        issue("nop_gap", NOP, 1'b0, 6'b000000);
        issue("sub_wb_fwd", enc_sub(5'd7, 5'd5, 5'd1), 1'b0, 6'b010000);
        drain();
    endtask

    task automatic test_load_use();
        issue("lw_x8", enc_lw(5'd8, 5'd1, 12'd0), 1'b0, 6'b000000);
        check_count("count_before_stall", 16'd0);
        issue("add_stalled", enc_add(5'd9, 5'd8, 5'd2), 1'b1, 6'b000000);
        check_count("count_after_stall", 16'd1);
        issue("add_ld_fwd", enc_add(5'd9, 5'd8, 5'd2), 1'b0, 6'b001000);
        check_count("count_held", 16'd1);
        drain();
    endtask

    task automatic test_younger_wins();
        issue("addi_x5_1", enc_addi(5'd5, 5'd0, 12'd1), 1'b0, 6'b000000);
        issue("addi_x5_2", enc_addi(5'd5, 5'd0, 12'd2), 1'b0, 6'b000000);
        issue("add_younger", enc_add(5'd6, 5'd5, 5'd0), 1'b0, 6'b100000);
        drain();
    endtask

    task automatic test_x0_and_unread();
        issue("lw_x0", enc_lw(5'd0, 5'd1, 12'd0), 1'b0, 6'b000000);
        issue("add_x0_src", enc_add(5'd3, 5'd0, 5'd0), 1'b0, 6'b000000);
        check_count("count_x0", 16'd1);
        drain();
        // addi imm=8 puts 8 in the rs2 field, which an I-type never reads
        issue("lw_x8_b", enc_lw(5'd8, 5'd1, 12'd0), 1'b0, 6'b000000);
        issue("addi_unread_rs2", enc_addi(5'd9, 5'd1, 12'd8), 1'b0, 6'b000000);
        drain();
        issue("lw_x8_c", enc_lw(5'd8, 5'd1, 12'd0), 1'b0, 6'b000000);
        issue("add_rs2_stalled", enc_add(5'd9, 5'd2, 5'd8), 1'b1, 6'b000000);
        issue("add_rs2_ld_fwd", enc_add(5'd9, 5'd2, 5'd8), 1'b0, 6'b000001);
        check_count("count_rs2", 16'd2);
        drain();
    endtask

    task automatic test_flush();
        issue("lw_x8_f", enc_lw(5'd8, 5'd1, 12'd0), 1'b0, 6'b000000);
        @(negedge clock);
        IFIDIR   = enc_add(5'd9, 5'd8, 5'd2);
        id_valid = 1'b1;
        flush    = 1'b1;
        #1;
        total++;
        if (stallID !== 1'b0)
            $display("FAIL flush_stall: stallID=%b expected 0", stallID);
        else
            passed++;
        sb.push_back('{"flush_bubble", 6'b000000});
        step();
        check_count("count_flush", 16'd2);
        drain();
    endtask

    task automatic test_freeze_and_reset();
        issue("addi_x5_fr", enc_addi(5'd5, 5'd0, 12'd1), 1'b0, 6'b000000);
        issue("lw_x8_fr", enc_lw(5'd8, 5'd5, 12'd0), 1'b0, 6'b100000);
        @(negedge clock);
        IFIDIR   = enc_add(5'd9, 5'd8, 5'd2);
        id_valid = 1'b1;
        pipe_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{"frozen_selects", 6'b100000});
            step();
            total++;
            if (stallID !== 1'b1)
                $display("FAIL frozen_stall: stallID=%b expected 1", stallID);
            else
                passed++;
            check_count("frozen_count", 16'd2);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (sel_now !== 6'b0 || stallID !== 1'b0)
            $display("FAIL async_reset_outputs: selects=%b stallID=%b expected 0", sel_now, stallID);
        else
            passed++;
        check_count("async_reset_count", 16'd0);
        @(negedge clock);
        reset   = 1'b0;
        pipe_en = 1'b1;
        issue("after_mid_reset", enc_add(5'd9, 5'd8, 5'd2), 1'b0, 6'b000000);
    endtask

    initial begin
        reset    = 1'b1;
        pipe_en  = 1'b1;
        flush    = 1'b0;
        id_valid = 1'b0;
        IFIDIR   = 32'h0;
        test_reset();
        test_alu_mem_forward();
        test_alu_wb_forward();
        test_load_use();
        test_younger_wins();
        test_x0_and_unread();
        test_flush();
        test_freeze_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
